// File: rtl/cam_pkg.sv
// Types and constants shared by the CAM arbiter controller and the CAM instance.
package cam_pkg;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } COMMAND;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        INSERT = 2'd2,
        RESP   = 2'd3
    } ctrl_state_t;

    localparam logic CAM_OP_LOOKUP = 1'b0;
    localparam logic CAM_OP_INSERT = 1'b1;

endpackage

// File: rtl/cam_arbiter_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping at NREQ.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    input  logic                    en,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_idx,
    output logic                    any
);

    localparam int IW = $clog2(NREQ);

    int slot_s;

    // Search upward from ptr; the first pending requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        slot_s    = 0;
        for (int i = 0; i < NREQ; i++) begin
            slot_s = (int'(ptr) + i) % NREQ;
            if (en && !any && req[slot_s]) begin
                grant[slot_s] = 1'b1;
                grant_idx     = IW'(slot_s);
                any           = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/cam_arbiter_ctrl.sv
// Shares one CAM between NREQ requesters: round-robin grant, READ then optional
// WRITE, deduplicated inserts with FIFO slot allocation.
module cam_arbiter_ctrl
    import cam_pkg::*;
#(
    parameter int SIZE = 8,
    parameter int NREQ = 4
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ-1:0]              req_op,
    input  logic [NREQ-1:0][31:0]        req_data,
    output logic [NREQ-1:0]              req_ready,
    output logic                         rsp_valid,
    output logic [$clog2(NREQ)-1:0]      rsp_id,
    output logic                         rsp_hit,
    output logic [$clog2(SIZE)-1:0]      rsp_idx,
    output logic                         rsp_evict,
    output logic [$clog2(SIZE):0]        occupancy,
    output logic                         cam_enable,
    output COMMAND                       cam_command,
    output logic [31:0]                  cam_data,
    output logic [$clog2(SIZE)-1:0]      cam_write_idx,
    input  logic [$clog2(SIZE)-1:0]      cam_read_idx,
    input  logic                         cam_hit
);

    localparam int IW = $clog2(NREQ);
    localparam int SW = $clog2(SIZE);
    localparam int OW = SW + 1;

    ctrl_state_t   state_r;
    logic [IW-1:0] rr_ptr_r;
    logic [SW-1:0] alloc_ptr_r;
    logic [OW-1:0] occ_r;
    logic [IW-1:0] id_r;
    logic          op_r;
    logic [31:0]   key_r;
    logic          rsp_valid_r;
    logic [IW-1:0] rsp_id_r;
    logic          rsp_hit_r;
    logic [SW-1:0] rsp_idx_r;
    logic          rsp_evict_r;
    logic          cam_enable_r;
    COMMAND        cam_command_r;
    logic [SW-1:0] cam_write_idx_r;

    logic [NREQ-1:0] grant_s;
    logic [IW-1:0]   grant_idx_s;
    logic            any_s;
    logic            arb_en_s;

    assign arb_en_s = (state_r == IDLE);

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_r),
        .en        (arb_en_s),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .any       (any_s)
    );

    assign req_ready     = grant_s;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_id        = rsp_id_r;
    assign rsp_hit       = rsp_hit_r;
    assign rsp_idx       = rsp_idx_r;
    assign rsp_evict     = rsp_evict_r;
    assign occupancy     = occ_r;
    assign cam_enable    = cam_enable_r;
    assign cam_command   = cam_command_r;
    assign cam_data      = key_r;
    assign cam_write_idx = cam_write_idx_r;

    // Request sequencer: grant, CAM READ, optional CAM WRITE, one-cycle response.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= IDLE;
            rr_ptr_r        <= '0;
            alloc_ptr_r     <= '0;
            occ_r           <= '0;
            id_r            <= '0;
            op_r            <= 1'b0;
            key_r           <= 32'h0000_0000;
            rsp_valid_r     <= 1'b0;
            rsp_id_r        <= '0;
            rsp_hit_r       <= 1'b0;
            rsp_idx_r       <= '0;
            rsp_evict_r     <= 1'b0;
            cam_enable_r    <= 1'b0;
            cam_command_r   <= READ;
            cam_write_idx_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    rsp_valid_r <= 1'b0;
                    if (any_s) begin
                        id_r          <= grant_idx_s;
                        op_r          <= req_op[grant_idx_s];
                        key_r         <= req_data[grant_idx_s];
                        rr_ptr_r      <= (grant_idx_s == IW'(NREQ - 1)) ? '0 : grant_idx_s + 1'b1;
                        cam_enable_r  <= 1'b1;
                        cam_command_r <= READ;
                        state_r       <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    // Only an insert that misses needs the WRITE cycle.
                    if (op_r == CAM_OP_INSERT && !cam_hit) begin
                        cam_command_r   <= WRITE;
                        cam_write_idx_r <= alloc_ptr_r;
                        state_r         <= INSERT;
                    end else begin
                        cam_enable_r <= 1'b0;
                        rsp_valid_r  <= 1'b1;
                        rsp_id_r     <= id_r;
                        rsp_hit_r    <= cam_hit;
                        rsp_idx_r    <= cam_read_idx;
                        rsp_evict_r  <= 1'b0;
                        state_r      <= RESP;
                    end
                end
                INSERT: begin
                    cam_enable_r  <= 1'b0;
                    cam_command_r <= READ;
                    rsp_valid_r   <= 1'b1;
                    rsp_id_r      <= id_r;
                    rsp_hit_r     <= 1'b0;
                    rsp_idx_r     <= alloc_ptr_r;
                    rsp_evict_r   <= (occ_r == OW'(SIZE));
                    alloc_ptr_r   <= (alloc_ptr_r == SW'(SIZE - 1)) ? '0 : alloc_ptr_r + 1'b1;
                    occ_r         <= (occ_r == OW'(SIZE)) ? occ_r : occ_r + 1'b1;
                    state_r       <= RESP;
                end
                RESP: begin
                    rsp_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    rsp_valid_r   <= 1'b0;
                    cam_enable_r  <= 1'b0;
                    cam_command_r <= READ;
                    state_r       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_arbiter_ctrl.sv
// Randomised bench for cam_arbiter_ctrl with a behavioural CAM and a key-history reference model.
module tb_cam_arbiter_ctrl;
    import cam_pkg::*;

    localparam int SIZE = 8;
    localparam int NREQ = 4;
    localparam int IW   = $clog2(NREQ);
    localparam int SW   = $clog2(SIZE);
    localparam int OW   = SW + 1;

    logic                  clock = 1'b0;
    logic                  reset_n = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_op = '0;
    logic [NREQ-1:0][31:0] req_data = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [IW-1:0]         rsp_id;
    logic                  rsp_hit;
    logic [SW-1:0]         rsp_idx;
    logic                  rsp_evict;
    logic [OW-1:0]         occupancy;
    logic                  cam_enable;
    COMMAND                cam_command;
    logic [31:0]           cam_data;
    logic [SW-1:0]         cam_write_idx;
    logic [SW-1:0]         cam_read_idx;
    logic                  cam_hit;

    always #5 clock = ~clock;

    cam_arbiter_ctrl #(.SIZE(SIZE), .NREQ(NREQ)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_op(req_op), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_hit(rsp_hit), .rsp_idx(rsp_idx),
        .rsp_evict(rsp_evict), .occupancy(occupancy),
        .cam_enable(cam_enable), .cam_command(cam_command), .cam_data(cam_data),
        .cam_write_idx(cam_write_idx), .cam_read_idx(cam_read_idx), .cam_hit(cam_hit)
    );

    // Behavioural CAM: lowest matching valid entry answers a READ combinationally.
    logic [31:0]     cm_key [SIZE];
    logic [SIZE-1:0] cm_vld;

    always_comb begin
        cam_hit      = 1'b0;
        cam_read_idx = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (cam_enable && cam_command == READ && cm_vld[i] && cm_key[i] == cam_data) begin
                cam_hit      = 1'b1;
                cam_read_idx = SW'(i);
            end
        end
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cm_vld <= '0;
        end else if (cam_enable && cam_command == WRITE) begin
            cm_vld[cam_write_idx] <= 1'b1;
            cm_key[cam_write_idx] <= cam_data;
        end
    end

    // Requester side and reference model state.
    logic [NREQ-1:0] act = '0;
    logic [NREQ-1:0] aop = '0;
    logic [31:0]     akey [NREQ];
    int              ins_no [logic [31:0]];
    int              ins_cnt = 0;
    int              rr_m = 0;
    bit              pend = 1'b0;
    int              g_cyc, r_cyc, p_id, p_idx, p_occ;
    bit              p_wr, p_hit, p_evict, p_chk_idx;
    logic [31:0]     p_key;
    int              cyc = 0;
    int              checks = 0;
    int              errors = 0;
    bit              reissue = 1'b0;
    bit              rand_mode = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit live(input logic [31:0] k);
        return ins_no.exists(k) && (ins_no[k] >= ins_cnt - SIZE);
    endfunction

    task automatic new_req(input int i);
        act[i]  = 1'b1;
        aop[i]  = 1'($urandom_range(0, 1));
        akey[i] = 32'h0000_1000 + 32'($urandom_range(0, 11));
    endtask

    task automatic set_req(input int i, input logic op, input logic [31:0] key);
        act[i]  = 1'b1;
        aop[i]  = op;
        akey[i] = key;
    endtask

    // The request that wins this cycle: predict its whole response from key history.
    task automatic grant(input int w);
        logic [31:0] key;
        key   = akey[w];
        p_key = key;
        p_id  = w;
        g_cyc = cyc;
        pend  = 1'b1;
        rr_m  = (w + 1) % NREQ;
        p_evict = 1'b0;
        if (live(key)) begin
            p_hit = 1'b1; p_idx = ins_no[key] % SIZE; p_chk_idx = 1'b1; p_wr = 1'b0; r_cyc = cyc + 2;
        end else if (aop[w] == CAM_OP_LOOKUP) begin
            p_hit = 1'b0; p_idx = 0; p_chk_idx = 1'b0; p_wr = 1'b0; r_cyc = cyc + 2;
        end else begin
            p_hit = 1'b0; p_idx = ins_cnt % SIZE; p_chk_idx = 1'b1; p_wr = 1'b1; r_cyc = cyc + 3;
            p_evict = (ins_cnt >= SIZE);
            ins_no[key] = ins_cnt;
            ins_cnt++;
        end
        p_occ  = (ins_cnt < SIZE) ? ins_cnt : SIZE;
        act[w] = 1'b0;
        if (reissue) new_req(w);
    endtask

    task automatic step();
        logic [NREQ-1:0] eg;
        int              w;
        int              idx;
        bit              in_cam;
        @(negedge clock);
        cyc++;
        if (rand_mode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!act[i] && $urandom_range(0, 3) == 0) new_req(i);
                else if (act[i] && $urandom_range(0, 15) == 0) act[i] = 1'b0;
            end
        end
        req_valid = act;
        req_op    = aop;
        for (int i = 0; i < NREQ; i++) req_data[i] = akey[i];
        #1;
        eg = '0;
        w  = -1;
        if (!pend) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (rr_m + k) % NREQ;
                if (w < 0 && act[idx]) w = idx;
            end
            if (w >= 0) eg[w] = 1'b1;
        end
        in_cam = pend && cyc > g_cyc && cyc < r_cyc;
        check_eq("req_ready", 32'(req_ready), 32'(eg));
        check_eq("rsp_valid", 32'(rsp_valid), 32'(pend && cyc == r_cyc));
        check_eq("cam_enable", 32'(cam_enable), 32'(in_cam));
        check_eq("cam_write_idx_range", 32'(int'(cam_write_idx) < SIZE), 32'd1);
        if (in_cam) begin
            check_eq("cam_command", 32'(cam_command), (p_wr && cyc == r_cyc - 1) ? 32'(WRITE) : 32'(READ));
            check_eq("cam_data", cam_data, p_key);
            if (p_wr && cyc == r_cyc - 1) check_eq("cam_write_idx", 32'(cam_write_idx), 32'(p_idx));
        end
        if (pend && cyc == r_cyc) begin
            check_eq("rsp_id", 32'(rsp_id), 32'(p_id));
            check_eq("rsp_hit", 32'(rsp_hit), 32'(p_hit));
            if (p_chk_idx) check_eq("rsp_idx", 32'(rsp_idx), 32'(p_idx));
            check_eq("rsp_evict", 32'(rsp_evict), 32'(p_evict));
            check_eq("occupancy", 32'(occupancy), 32'(p_occ));
            pend = 1'b0;
        end
        if (w >= 0) grant(w);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((pend || act != '0) && n < 200) begin
            step();
            n++;
        end
        check_eq("drain_timeout", 32'(pend || act != '0), 32'd0);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        act       = '0;
        req_valid = '0;
        pend      = 1'b0;
        reissue   = 1'b0;
        rand_mode = 1'b0;
        ins_no.delete();
        ins_cnt   = 0;
        rr_m      = 0;
        #1;
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_fields", 32'({rsp_id, rsp_hit, rsp_idx, rsp_evict}), 32'd0);
        check_eq("rst_occupancy", 32'(occupancy), 32'd0);
        check_eq("rst_cam_enable", 32'(cam_enable), 32'd0);
        check_eq("rst_cam_command", 32'(cam_command), 32'(READ));
        check_eq("rst_cam_data", cam_data, 32'h0000_0000);
        check_eq("rst_cam_write_idx", 32'(cam_write_idx), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) akey[i] = 32'h0000_0000;
        #2;
        do_reset();

        // Insert, lookup from another requester, then a duplicate insert.
        set_req(0, CAM_OP_INSERT, 32'hDEAD_BEEF); drain();
        set_req(2, CAM_OP_LOOKUP, 32'hDEAD_BEEF); drain();
        set_req(1, CAM_OP_INSERT, 32'hDEAD_BEEF); drain();
        check_eq("occ_after_dedup", 32'(occupancy), 32'd1);

        // Every requester continuously valid: rotation 0,1,2,3,...
        do_reset();
        reissue = 1'b1;
        for (int i = 0; i < NREQ; i++) new_req(i);
        repeat (40) step();
        reissue = 1'b0;
        drain();

        // Fill all slots, then one more insert overwrites slot 0.
        do_reset();
        for (int k = 0; k < SIZE; k++) begin
            set_req(k % NREQ, CAM_OP_INSERT, 32'h0000_0100 + 32'(k));
            drain();
        end
        set_req(1, CAM_OP_INSERT, 32'h0000_0200); drain();
        check_eq("occ_full", 32'(occupancy), 32'(SIZE));
        set_req(2, CAM_OP_LOOKUP, 32'h0000_0100); drain();

        // Reset arriving in the middle of the WRITE cycle.
        do_reset();
        set_req(3, CAM_OP_INSERT, 32'h0000_0300);
        repeat (3) step();
        check_eq("mid_insert_cmd", 32'(cam_command), 32'(WRITE));
        do_reset();
        repeat (3) step();
        set_req(0, CAM_OP_INSERT, 32'h0000_0301); drain();

        // Random traffic against the key-history model.
        rand_mode = 1'b1;
        repeat (600) step();
        rand_mode = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_arbiter_ctrl.md
Name: cam_arbiter_ctrl

Overview:
- Shares one CAM instance (SIZE entries, 32-bit keys, READ/WRITE command) between NREQ requesters.
- Arbitrates lookup and insert requests round-robin and sequences each one as CAM READ, then an optional CAM WRITE.
- Inserts are deduplicated: a key already present is not written again.
- Write slots are allocated FIFO-style: the oldest slot is overwritten once the CAM is full. Sits between client pipelines and the CAM.

Parameters:
- SIZE, 8, number of CAM entries (must match the CAM instance).
- NREQ, 4, number of requesters (at least 2).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request pending.
- req_op  in  NREQ  per-requester op: 0 = lookup, 1 = insert.
- req_data  in  NREQ x 32  per-requester key.
- req_ready  out  NREQ  one-hot grant pulse; request accepted this cycle.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_id  out  $clog2(NREQ)  requester that owns the response.
- rsp_hit  out  1  key was found in the CAM.
- rsp_idx  out  $clog2(SIZE)  matching index on a hit, or written index on an insert-miss.
- rsp_evict  out  1  insert-miss overwrote a valid entry.
- occupancy  out  $clog2(SIZE)+1  number of valid entries written.
- cam_enable  out  1  to CAM enable.
- cam_command  out  COMMAND  to CAM command.
- cam_data  out  32  to CAM data.
- cam_write_idx  out  $clog2(SIZE)  to CAM write_idx.
- cam_read_idx  in  $clog2(SIZE)  from CAM read_idx.
- cam_hit  in  1  from CAM hit (combinational in the READ cycle).

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, rr_ptr=0, alloc_ptr=0, occupancy=0.
  - All outputs 0; cam_command=READ.
  - Any in-flight request is dropped with no response.
- State IDLE:
  - cam_enable=0.
  - If any req_valid, pick the first set bit searching from rr_ptr upward, wrapping at NREQ.
  - Pulse req_ready[winner] for that cycle only.
  - Latch id, op and data; rr_ptr <= winner+1 mod NREQ; go to LOOKUP.
  - No req_valid: stay in IDLE.
- State LOOKUP:
  - cam_enable=1, cam_command=READ, cam_data=latched key.
  - Sample cam_hit/cam_read_idx at the clock edge ending the cycle.
  - op=lookup: record hit and idx; go to RESP.
  - op=insert and hit: record hit=1, idx=cam_read_idx, no write; go to RESP.
  - op=insert and miss: go to INSERT.
- State INSERT:
  - cam_enable=1, cam_command=WRITE, cam_data=key, cam_write_idx=alloc_ptr.
  - Record hit=0, idx=alloc_ptr, evict=(occupancy==SIZE).
  - alloc_ptr <= alloc_ptr+1, wrapping SIZE-1 to 0.
  - occupancy increments, saturating at SIZE.
  - Go to RESP.
- State RESP:
  - rsp_valid=1 with registered rsp_id/hit/idx/evict; cam_enable=0; go to IDLE.
  - rsp_* hold their last values when rsp_valid=0.
- Latency from the grant cycle to rsp_valid: lookup or insert-hit = 2 cycles; insert-miss = 3 cycles.
- Throughput: one request in flight at a time. No grant in LOOKUP, INSERT or RESP; next grant earliest the cycle after RESP.
- Requester rules:
  - Hold req_valid, req_op and req_data stable until req_ready.
  - Dropping req_valid before the grant is legal; the request is simply not served.
- Simultaneous requests: exactly one grant per arbitration. A requester that is always valid is granted at least once every NREQ arbitrations.
- cam_enable is never high outside LOOKUP/INSERT; cam_write_idx is always < SIZE.

Decomposition:
- Shared package cam_pkg:
  - COMMAND enum {READ, WRITE}, shared with the CAM.
  - ctrl_state_t enum {IDLE, LOOKUP, INSERT, RESP}.
  - CAM_OP_LOOKUP=1'b0, CAM_OP_INSERT=1'b1.
- One sub-module, rr_arbiter #(NREQ):
  - Inputs: req vector, rr_ptr, arbitration enable.
  - Outputs: one-hot grant, grant index, any.
  - The controller owns rr_ptr.

Test Plan:
- Reset, then req 0 inserts 0xDEADBEEF → INSERT cycle has cam_write_idx=0. RESP: rsp_id=0, rsp_hit=0, rsp_idx=0, rsp_evict=0, occupancy=1.
- Then req 2 looks up 0xDEADBEEF → rsp_valid 2 cycles after grant: rsp_id=2, rsp_hit=1, rsp_idx=0. No WRITE cycle.
- Insert 0xDEADBEEF again → rsp_hit=1, rsp_idx=0, no WRITE issued, occupancy unchanged at 1.
- All 4 requesters hold req_valid continuously → grants in order 0,1,2,3,0,… One response per request with matching rsp_id.
- Fill with 8 distinct keys 0x100..0x107, then insert 0x200 → cam_write_idx=0, rsp_evict=1, occupancy=8. A following lookup of 0x100 returns rsp_hit=0.
- Assert reset_n=0 during the INSERT cycle → outputs go to 0 immediately. No rsp_valid for that request; the next insert writes idx 0.
